// File: rtl/alu_sequencer.sv
// Command scheduler: queues decoded commands, issues them to the ALU one at a
// time and streams each 32-bit result to the UART as a 7-byte framed response.
module alu_sequencer #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] HDR_BYTE   = 8'hA5,
  parameter logic [7:0] TAIL_BYTE  = 8'hBD
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        parser_done,
  input  logic [3:0]  data_type,
  input  logic [4:0]  operator,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  output logic        alu_start,
  output logic [3:0]  alu_data_type,
  output logic [4:0]  alu_operator,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        alu_error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overflow
);
  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam int          CMD_W      = 41;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_IDX   = 3'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;
  state_t state_reg, state_next;

  logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic [CMD_W-1:0] cmd_reg;
  logic [15:0]      wait_cnt_reg;
  logic [31:0]      result_reg;
  logic [7:0]       status_reg;
  logic [2:0]       byte_idx_reg;
  logic             overflow_reg;
  logic [7:0]       frame [8];
  logic             pop, push, timed_out;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign push      = parser_done && ((count_reg != FULL_COUNT) || pop);
  assign timed_out = (wait_cnt_reg == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {data_type, operator, src1, src2};
  end

  assign frame[0] = HDR_BYTE;
  assign frame[1] = status_reg;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_res_bytes
      assign frame[gi+2] = result_reg[31-8*gi -: 8];
    end
  endgenerate
  assign frame[6] = TAIL_BYTE;
  assign frame[7] = 8'h00;

  always_comb begin
    state_next = state_reg;
    alu_start  = 1'b0;
    tx_valid   = 1'b0;
    case (state_reg)
      IDLE:  if (count_reg != '0) state_next = ISSUE;
      ISSUE: begin
        alu_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (alu_done || timed_out) state_next = SEND;
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && (byte_idx_reg == LAST_IDX)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      cmd_reg      <= '0;
      wait_cnt_reg <= '0;
      result_reg   <= '0;
      status_reg   <= '0;
      byte_idx_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      overflow_reg <= parser_done && !push;
      count_reg    <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        cmd_reg    <= fifo_mem[rd_ptr_reg];
      end
      case (state_reg)
        ISSUE: wait_cnt_reg <= '0;
        WAIT: begin
          // A completion arriving on the timeout cycle still counts as normal.
          if (alu_done) begin
            result_reg   <= alu_result;
            status_reg   <= alu_error ? 8'h01 : 8'h00;
            byte_idx_reg <= '0;
          end else if (timed_out) begin
            result_reg   <= '0;
            status_reg   <= 8'h02;
            byte_idx_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        SEND: if (tx_ready) byte_idx_reg <= byte_idx_reg + 3'd1;
        default: ;
      endcase
    end
  end

  assign alu_data_type = cmd_reg[40:37];
  assign alu_operator  = cmd_reg[36:32];
  assign alu_src1      = cmd_reg[31:16];
  assign alu_src2      = cmd_reg[15:0];
  assign tx_data       = tx_valid ? frame[byte_idx_reg] : 8'h00;
  assign busy          = (state_reg != IDLE) || (count_reg != '0);
  assign overflow      = overflow_reg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios with literal frame expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_alu_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 10;

  logic clk = 1'b0;
  logic n_rst, parser_done;
  logic [3:0] data_type;
  logic [4:0] op;
  logic [15:0] src1, src2;
  logic alu_start, alu_done, alu_error, tx_valid, tx_ready, busy, overflow;
  logic [3:0] alu_data_type;
  logic [4:0] alu_operator;
  logic [15:0] alu_src1, alu_src2;
  logic [31:0] alu_result;
  logic [7:0] tx_data;

  alu_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .HDR_BYTE(8'hA5), .TAIL_BYTE(8'hBD)) dut (
    .clk(clk), .n_rst(n_rst), .parser_done(parser_done), .data_type(data_type),
    .operator(op), .src1(src1), .src2(src2), .alu_start(alu_start),
    .alu_data_type(alu_data_type), .alu_operator(alu_operator), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_done(alu_done), .alu_result(alu_result),
    .alu_error(alu_error), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [3:0] dt;
    logic [4:0] op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  // Model: command queue, engine phase flags and the bytes still owed to the UART.
  cmd_t m_q[$];
  cmd_t m_cur;
  bit m_idle, m_issue, m_wait, m_ovf, prev_low;
  int m_wcnt;
  logic [7:0] m_frame[$];

  logic [7:0] got[$];
  int got_cyc[$];
  int start_cyc[$];
  int ovf_cnt = 0;
  int done_cyc = 0;

  task automatic m_reset();
    m_q.delete();
    m_frame.delete();
    m_cur = '0;
    m_idle = 1;
    m_issue = 0;
    m_wait = 0;
    m_ovf = 0;
    m_wcnt = 0;
  endtask

  task automatic m_build(input logic [7:0] status, input logic [31:0] r);
    m_frame.push_back(8'hA5);
    m_frame.push_back(status);
    for (int i = 3; i >= 0; i--) m_frame.push_back(r[8*i +: 8]);
    m_frame.push_back(8'hBD);
  endtask

  initial begin
    bit pop;
    m_reset();
    prev_low = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        if (prev_low) begin
          chk("reset_alu_start", 64'(alu_start), 64'd0);
          chk("reset_busy", 64'(busy), 64'd0);
          chk("reset_tx_valid", 64'(tx_valid), 64'd0);
          chk("reset_overflow", 64'(overflow), 64'd0);
          chk("reset_outputs", 64'({alu_data_type, alu_operator, alu_src1, alu_src2, tx_data}), 64'd0);
        end
        prev_low = 1;
        m_reset();
      end else begin
        prev_low = 0;
        chk("busy", 64'(busy), 64'(!m_idle || m_q.size() > 0));
        chk("alu_start", 64'(alu_start), 64'(m_issue));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("tx_valid", 64'(tx_valid), 64'(m_frame.size() > 0));
        if (m_frame.size() > 0) chk("tx_data", 64'(tx_data), 64'(m_frame[0]));
        chk("alu_operands", 64'({alu_data_type, alu_operator, alu_src1, alu_src2}), 64'(m_cur));
        if (alu_start) start_cyc.push_back(cyc);
        if (overflow) ovf_cnt++;
        if (alu_done) done_cyc = cyc;
        if (tx_valid && tx_ready) begin
          got.push_back(tx_data);
          got_cyc.push_back(cyc);
        end
        pop = m_idle && (m_q.size() > 0);
        m_ovf = parser_done && (m_q.size() == DEPTH) && !pop;
        if (m_issue) begin
          m_issue = 0;
          m_wait = 1;
          m_wcnt = 0;
        end else if (m_wait) begin
          if (alu_done) begin
            m_build(alu_error ? 8'h01 : 8'h00, alu_result);
            m_wait = 0;
          end else begin
            m_wcnt++;
            if (m_wcnt == TMO) begin
              m_build(8'h02, 32'h0);
              m_wait = 0;
            end
          end
        end else if (m_frame.size() > 0 && tx_ready) begin
          void'(m_frame.pop_front());
          if (m_frame.size() == 0) m_idle = 1;
        end
        if (pop) begin
          m_cur = m_q.pop_front();
          m_idle = 0;
          m_issue = 1;
        end
        if (parser_done && !m_ovf) m_q.push_back({data_type, op, src1, src2});
      end
    end
  end

  // ALU responder: answers resp_delay cycles after alu_start; 0 means never.
  int resp_delay = 3;
  logic [31:0] resp_result = 32'h0;
  logic resp_error = 1'b0;
  bit rand_mode = 0;
  initial begin
    int cd;
    cd = 0;
    alu_done = 0;
    alu_result = 0;
    alu_error = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) cd = 0;
      else if (alu_start) begin
        if (rand_mode) begin
          resp_delay = $urandom_range(1, 12);
          resp_result = $urandom;
          resp_error = ($urandom_range(0, 3) == 0);
        end
        cd = resp_delay;
      end
      @(posedge clk);
      #1;
      alu_done = 0;
      alu_result = $urandom;
      alu_error = $urandom_range(0, 1) == 1;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          alu_done = 1;
          alu_result = resp_result;
          alu_error = resp_error;
        end
      end else if (rand_mode && $urandom_range(0, 19) == 0) alu_done = 1;
    end
  end

  int tx_mode = 0;
  initial begin
    int ph;
    ph = 0;
    tx_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0: tx_ready = 1;
        1: begin
          tx_ready = (ph % 3 == 0);
          ph++;
        end
        default: tx_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] dt, input logic [4:0] o, input logic [15:0] a,
                      input logic [15:0] b);
    parser_done = 1;
    data_type = dt;
    op = o;
    src1 = a;
    src2 = b;
    tick();
    parser_done = 0;
  endtask

  task automatic clear_mon();
    got.delete();
    got_cyc.delete();
    start_cyc.delete();
    ovf_cnt = 0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(got.size() >= n), 64'd1);
  endtask

  task automatic chk_frame(input string name, input logic [55:0] e);
    if (got.size() < 7) chk({name, "_len"}, 64'(got.size()), 64'd7);
    else for (int i = 0; i < 7; i++)
      chk($sformatf("%s_b%0d", name, i), 64'(got[i]), 64'(e[55-8*i -: 8]));
  endtask

  initial begin
    int n0, k;
    n_rst = 0;
    parser_done = 1;
    data_type = 4'h3;
    op = 5'h1;
    src1 = 16'h1111;
    src2 = 16'h2222;
    repeat (3) tick();
    parser_done = 0;
    n_rst = 1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_start", 64'(alu_start), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    repeat (3) tick();
    chk("rst_no_start", 64'(start_cyc.size()), 64'd0);

    // Single op, no back-pressure.
    clear_mon();
    resp_delay = 3;
    resp_result = 32'h7;
    resp_error = 0;
    n0 = cyc;
    push(4'h0, 5'h0, 16'h0003, 16'h0004);
    wait_bytes(7, 60, "t2_bytes");
    if (start_cyc.size() == 0) chk("t2_start_seen", 64'd0, 64'd1);
    else chk("t2_start_latency", 64'(start_cyc[0]), 64'(n0 + 2));
    chk_frame("t2_frame", 56'hA5_00_00_00_00_07_BD);
    if (got_cyc.size() >= 7) begin
      chk("t2_first_tx", 64'(got_cyc[0]), 64'(done_cyc + 1));
      for (int i = 1; i < 7; i++) chk("t2_no_bubble", 64'(got_cyc[i]), 64'(got_cyc[0] + i));
    end
    repeat (3) tick();

    // Back-pressure pattern 1,0,0.
    clear_mon();
    tx_mode = 1;
    resp_delay = 2;
    resp_result = 32'h12345678;
    push(4'h2, 5'h3, 16'hAAAA, 16'h5555);
    wait_bytes(7, 80, "t3_bytes");
    chk_frame("t3_frame", 56'hA5_00_12_34_56_78_BD);
    tx_mode = 0;
    repeat (5) tick();

    // Overflow with a stalled ALU: 6 pushes back to back.
    clear_mon();
    resp_delay = 0;
    for (int i = 0; i < 6; i++) push(4'(i), 5'(i + 8), 16'(i * 16'h101), 16'(16'hF000 + i));
    wait_bytes(35, 400, "t4_bytes");
    chk("t4_overflow_pulses", 64'(ovf_cnt), 64'd1);
    chk("t4_starts", 64'(start_cyc.size()), 64'd5);
    for (int i = 0; i < 5 && got.size() >= 35; i++)
      chk("t4_timeout_status", 64'(got[7*i+1]), 64'h02);
    repeat (3) tick();

    // Timeout, then error result.
    clear_mon();
    resp_delay = 0;
    push(4'h1, 5'h2, 16'h0001, 16'h0002);
    wait_bytes(7, 60, "t5a_bytes");
    chk_frame("t5a_frame", 56'hA5_02_00_00_00_00_BD);
    if (start_cyc.size() > 0 && got_cyc.size() > 0)
      chk("t5a_timeout_len", 64'(got_cyc[0] - start_cyc[0]), 64'(TMO + 1));
    repeat (2) tick();
    clear_mon();
    resp_delay = 2;
    resp_result = 32'hDEADBEEF;
    resp_error = 1;
    push(4'h4, 5'h4, 16'h0010, 16'h0020);
    wait_bytes(7, 60, "t5b_bytes");
    chk_frame("t5b_frame", 56'hA5_01_DE_AD_BE_EF_BD);
    repeat (2) tick();
    // Completion on the last allowed wait cycle wins; one later is a timeout.
    clear_mon();
    resp_delay = TMO;
    resp_result = 32'h55;
    resp_error = 0;
    push(4'h5, 5'h5, 16'h0030, 16'h0040);
    wait_bytes(7, 60, "t5c_bytes");
    chk_frame("t5c_frame", 56'hA5_00_00_00_00_55_BD);
    repeat (2) tick();
    clear_mon();
    resp_delay = TMO + 1;
    push(4'h6, 5'h6, 16'h0050, 16'h0060);
    wait_bytes(7, 60, "t5d_bytes");
    chk_frame("t5d_frame", 56'hA5_02_00_00_00_00_BD);
    repeat (4) tick();

    // Reset in the middle of a frame.
    clear_mon();
    resp_delay = 1;
    resp_result = 32'hCAFEF00D;
    push(4'h7, 5'h7, 16'h0070, 16'h0080);
    wait_bytes(3, 40, "t6_partial");
    n_rst = 0;
    tick();
    n_rst = 1;
    chk("t6_tx_valid_dropped", 64'(tx_valid), 64'd0);
    chk("t6_busy_cleared", 64'(busy), 64'd0);
    repeat (2) tick();
    clear_mon();
    resp_result = 32'h1;
    push(4'h8, 5'h8, 16'h0090, 16'h00A0);
    wait_bytes(7, 60, "t6_bytes");
    chk_frame("t6_frame", 56'hA5_00_00_00_00_01_BD);
    repeat (3) tick();

    // Randomized traffic.
    rand_mode = 1;
    tx_mode = 2;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 12)) tick();
      push(4'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
    end
    k = 0;
    while (busy && k < 6000) begin
      tick();
      k++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
